load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit for the pipelined RISC-V core. It sits between the M-stage pipeline register and the data-memory port. It consumes the `storeType` and `truncType` control fields decoded upstream. For stores it generates byte enables and lane-aligned write data; for loads it extracts and sign- or zero-extends the returned data. A req/ack FSM stalls the pipeline until memory responds.

## Interface
- `XLEN`, default 32: datapath width, 32 or 64 (64 when `XLEN_64` is defined).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  M-stage instruction is a load or store.
- `req_is_store`  in  1  1 means store, 0 means load.
- `req_addr`  in  XLEN  effective byte address.
- `req_wdata`  in  XLEN  store data, LSB-justified.
- `req_store_type`  in  2  `HighLevelControl::storeType`.
- `req_trunc_type`  in  3  `HighLevelControl::truncType`.
- `flush`  in  1  squash the M-stage instruction.
- `stall_m`  out  1  hold the M stage and all upstream stages.
- `misaligned`  out  1  one-cycle alignment-fault pulse.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  XLEN  `req_addr` with the low log2(XLEN/8) bits cleared.
- `mem_be`  out  XLEN/8  byte enables.
- `mem_wdata`  out  XLEN  lane-shifted store data.
- `mem_ack`  in  1  memory completion, valid only while `mem_req` is high.
- `mem_rdata`  in  XLEN  read data, valid with `mem_ack`.
- `load_valid`  out  1  one-cycle pulse: `load_data` is new.
- `load_data`  out  XLEN  extended load result, held until the next load completes.

## Operation
- FSM states: IDLE, WAIT_ACK, DONE. A squash flag is set in WAIT_ACK.
- Byte offset `off` = `req_addr[log2(XLEN/8)-1:0]`.
- Alignment faults:
  - half: `off[0]` != 0.
  - word: `off[1:0]` != 0.
  - double: `off` != 0.
  - `Store_Double_Word` when XLEN=32 is always a fault.
  - A load's width is taken from `req_trunc_type`; `NO_TRUNC` means XLEN-wide.
- IDLE with `req_valid`, no `flush`, no fault: latch address, data, be, we and trunc type, then go to WAIT_ACK.
- IDLE with `req_valid` and a fault: pulse `misaligned` next cycle, issue no memory request, stay in IDLE, `stall_m` stays 0.
- IDLE with `flush`: the request is ignored.
- WAIT_ACK: `mem_req`=1 with all latched fields stable.
  - `mem_ack`=1: go to DONE. For a load that is not squashed, register the extended data.
  - `flush` in WAIT_ACK sets squash. The bus transaction still completes, but no `load_valid` is produced.
- DONE: one cycle. `req_valid` is ignored because the M-stage instruction is still present; then return to IDLE.
- Store byte enables: byte `1<<off`, half `3<<off`, word `0xF<<off`, double all ones.
  - `mem_wdata` = `req_wdata << (8*off)`.
- Load path: shift `mem_rdata >> (8*off)`, then extend.
  - `BYTE` / `HALF_WORD` / `WORD`: sign-extend from bit 7 / 15 / 31.
  - `*_UNSIGNED`: zero-extend.
  - `NO_TRUNC`: pass through.
- Loads use `mem_be` = all ones and `mem_we`=0.

## Timing
- Reset (asynchronous, any state):
  - state goes to IDLE and squash clears.
  - `mem_req`, `mem_we`, `mem_be`, `load_valid` and `misaligned` go to 0.
  - `mem_addr`, `mem_wdata` and `load_data` go to 0.
  - A transaction in flight is abandoned; `mem_ack` during reset is ignored.
- `stall_m` is combinational: (IDLE and `req_valid` and not `flush` and not fault) or WAIT_ACK. It is 0 in DONE.
- `mem_req` is registered, equal to (state == WAIT_ACK), and is high from the cycle after acceptance until and including the `mem_ack` cycle.
- Minimum latency: accept in cycle 0, `mem_req` in cycle 1 with ack, DONE in cycle 2.
  - `load_valid` and `load_data` are valid in cycle 2.
  - `stall_m` is high in cycles 0 and 1.
- Each extra wait cycle on `mem_ack` adds one stall cycle.
- `mem_ack` while not in WAIT_ACK is ignored.

## Test plan
- XLEN=32. Load `BYTE` at 0x1003, `mem_rdata`=0x80FF_1234, ack on first request cycle -> `mem_addr`=0x1000, `stall_m` high for 2 cycles, `load_data`=0xFFFF_FF80 with a 1-cycle `load_valid` in cycle 2.
- Store `Store_Half_Word` at 0x2002, `req_wdata`=0xABCD -> `mem_be`=0b1100, `mem_wdata`=0xABCD_0000, `mem_we`=1, no `load_valid`.
- Load `WORD` at 0x3001 -> `misaligned` pulses once, `mem_req` never rises, `stall_m`=0.
- Load `HALF_WORD_UNSIGNED` at 0x4002 with ack delayed 3 cycles and `mem_rdata`=0x9876_0000 -> `stall_m` high for 4 cycles, `load_data`=0x0000_9876.
- `flush` during WAIT_ACK, then ack -> transaction completes, `load_valid` stays 0, FSM returns to IDLE.
- `reset_n` driven low during WAIT_ACK -> `mem_req` drops immediately, all outputs 0, and a new load after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: aligns store data and byte enables, extends load data,
// and stalls the pipeline with a req/ack handshake until data memory responds.
`timescale 1ns/1ps

module load_store_unit #(
`ifdef XLEN_64
   parameter int XLEN = 64
`else
   parameter int XLEN = 32
`endif
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                req_valid,
   input  logic                req_is_store,
   input  logic [XLEN-1:0]     req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [1:0]          req_store_type,
   input  logic [2:0]          req_trunc_type,
   input  logic                flush,
   output logic                stall_m,
   output logic                misaligned,
   output logic                mem_req,
   output logic                mem_we,
   output logic [XLEN-1:0]     mem_addr,
   output logic [XLEN/8-1:0]   mem_be,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_ack,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic                load_valid,
   output logic [XLEN-1:0]     load_data
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   localparam logic [1:0] STORE_BYTE        = 2'd0;
   localparam logic [1:0] STORE_HALF_WORD   = 2'd1;
   localparam logic [1:0] STORE_WORD        = 2'd2;
   localparam logic [1:0] STORE_DOUBLE_WORD = 2'd3;

   localparam logic [2:0] BYTE               = 3'd0;
   localparam logic [2:0] HALF_WORD          = 3'd1;
   localparam logic [2:0] WORD               = 3'd2;
   localparam logic [2:0] BYTE_UNSIGNED      = 3'd3;
   localparam logic [2:0] HALF_WORD_UNSIGNED = 3'd4;
   localparam logic [2:0] WORD_UNSIGNED      = 3'd5;

   typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_e;

   state_e            state_q, state_d;
   logic              squash_q, squash_d;
   logic              mem_we_q, mem_we_d;
   logic [NB-1:0]     mem_be_q, mem_be_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [OFFW-1:0]   off_q, off_d;
   logic [2:0]        trunc_q, trunc_d;
   logic              load_valid_q, load_valid_d;
   logic [XLEN-1:0]   load_data_q, load_data_d;
   logic              misaligned_q, misaligned_d;

   logic [OFFW-1:0]   off;
   logic [1:0]        size;
   logic              fault;
   logic [NB-1:0]     be;
   logic [XLEN-1:0]   rdata_shifted;
   logic [XLEN-1:0]   load_ext;

   assign off = req_addr[OFFW-1:0];

   // Access size as log2(bytes); loads derive it from the truncation type.
   always_comb begin
      size = 2'd0;
      if (req_is_store) begin
         size = req_store_type;
      end else begin
         case (req_trunc_type)
            BYTE, BYTE_UNSIGNED:           size = 2'd0;
            HALF_WORD, HALF_WORD_UNSIGNED: size = 2'd1;
            WORD, WORD_UNSIGNED:           size = 2'd2;
            default:                       size = (XLEN == 64) ? 2'd3 : 2'd2;
         endcase
      end
   end

   always_comb begin
      fault = 1'b0;
      be    = '1;
      case (size)
         2'd0: fault = 1'b0;
         2'd1: fault = off[0];
         2'd2: fault = (off[1:0] != 2'b00);
         default: fault = (XLEN == 32) || (off != '0);
      endcase
      if (req_is_store) begin
         case (req_store_type)
            STORE_BYTE:      be = NB'(1) << off;
            STORE_HALF_WORD: be = NB'(3) << off;
            STORE_WORD:      be = NB'(15) << off;
            default:         be = '1;
         endcase
      end
   end

   always_comb begin
      rdata_shifted = mem_rdata >> {off_q, 3'b000};
      case (trunc_q)
         BYTE:               load_ext = XLEN'($signed(rdata_shifted[7:0]));
         HALF_WORD:          load_ext = XLEN'($signed(rdata_shifted[15:0]));
         WORD:               load_ext = XLEN'($signed(rdata_shifted[31:0]));
         BYTE_UNSIGNED:      load_ext = XLEN'(rdata_shifted[7:0]);
         HALF_WORD_UNSIGNED: load_ext = XLEN'(rdata_shifted[15:0]);
         WORD_UNSIGNED:      load_ext = XLEN'(rdata_shifted[31:0]);
         default:            load_ext = rdata_shifted;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      squash_d     = squash_q;
      mem_we_d     = mem_we_q;
      mem_be_d     = mem_be_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      off_d        = off_q;
      trunc_d      = trunc_q;
      load_valid_d = 1'b0;
      load_data_d  = load_data_q;
      misaligned_d = 1'b0;
      stall_m      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && !flush) begin
               if (fault) begin
                  misaligned_d = 1'b1;
               end else begin
                  stall_m     = 1'b1;
                  state_d     = WAIT_ACK;
                  squash_d    = 1'b0;
                  mem_we_d    = req_is_store;
                  mem_be_d    = be;
                  mem_addr_d  = {req_addr[XLEN-1:OFFW], OFFW'(0)};
                  mem_wdata_d = req_wdata << {off, 3'b000};
                  off_d       = off;
                  trunc_d     = req_trunc_type;
               end
            end
         end
         WAIT_ACK: begin
            stall_m = 1'b1;
            if (flush) squash_d = 1'b1;
            // A flush arriving with the ack still squashes the result.
            if (mem_ack) begin
               state_d = DONE;
               if (!mem_we_q && !squash_q && !flush) begin
                  load_valid_d = 1'b1;
                  load_data_d  = load_ext;
               end
            end
         end
         DONE: begin
            state_d  = IDLE;
            squash_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         squash_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         off_q        <= '0;
         trunc_q      <= '0;
         load_valid_q <= 1'b0;
         load_data_q  <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         squash_q     <= squash_d;
         mem_we_q     <= mem_we_d;
         mem_be_q     <= mem_be_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         off_q        <= off_d;
         trunc_q      <= trunc_d;
         load_valid_q <= load_valid_d;
         load_data_q  <= load_data_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign mem_req    = (state_q == WAIT_ACK);
   assign mem_we     = mem_we_q;
   assign mem_be     = mem_be_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign load_valid = load_valid_q;
   assign load_data  = load_data_q;
   assign misaligned = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit at XLEN=32: scenario tasks with a queue
// of expected memory/load results popped as the DUT produces them.
`timescale 1ns/1ps

module tb_load_store_unit;

   localparam logic [1:0] ST_BYTE = 2'd0;
   localparam logic [1:0] ST_HALF = 2'd1;
   localparam logic [1:0] ST_WORD = 2'd2;

   localparam logic [2:0] TT_BYTE   = 3'd0;
   localparam logic [2:0] TT_HALF   = 3'd1;
   localparam logic [2:0] TT_WORD   = 3'd2;
   localparam logic [2:0] TT_BYTE_U = 3'd3;
   localparam logic [2:0] TT_HALF_U = 3'd4;
   localparam logic [2:0] TT_NONE   = 3'd6;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] data;
   } expect_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_is_store, flush, mem_ack;
   logic [31:0] req_addr, req_wdata, mem_rdata;
   logic [1:0]  req_store_type;
   logic [2:0]  req_trunc_type;
   logic        stall_m, misaligned, mem_req, mem_we, load_valid;
   logic [31:0] mem_addr, mem_wdata, load_data;
   logic [3:0]  mem_be;

   int          checks = 0;
   int          errors = 0;
   expect_t     sb[$];

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(32)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_is_store(req_is_store),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_store_type(req_store_type),
      .req_trunc_type(req_trunc_type), .flush(flush), .stall_m(stall_m),
      .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .load_valid(load_valid), .load_data(load_data)
   );

   // Reference extraction built byte by byte from the returned word.
   function automatic logic [31:0] model_load(logic [31:0] rd, logic [1:0] off, logic [2:0] tt);
      logic [7:0]  b[4];
      logic [31:0] v;
      int          o;
      for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
      o = int'(off);
      case (tt)
         TT_BYTE:   v = {{24{b[o][7]}}, b[o]};
         TT_BYTE_U: v = {24'h0, b[o]};
         TT_HALF:   v = {{16{b[o+1][7]}}, b[o+1], b[o]};
         TT_HALF_U: v = {16'h0, b[o+1], b[o]};
         default:   v = {b[3], b[2], b[1], b[0]};
      endcase
      return v;
   endfunction

   // Drives one M-stage request, plays the memory side and records what the DUT did.
   task automatic run_txn(input logic is_store, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] st, input logic [2:0] tt, input logic [31:0] rdata,
                          input int ack_at, input int flush_at,
                          output int stalls, output int reqs, output int lvs, output int miss,
                          output logic [31:0] lv_data, output logic [31:0] a, output logic [3:0] be,
                          output logic [31:0] wd, output logic we, output logic timed_out);
      int   tail;
      logic drop;
      stalls = 0; reqs = 0; lvs = 0; miss = 0;
      lv_data = 'x; a = 'x; be = 'x; wd = 'x; we = 1'bx;
      timed_out = 1'b1;
      tail = -1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_is_store = is_store; req_addr = addr; req_wdata = wdata;
      req_store_type = st; req_trunc_type = tt;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (stall_m) stalls++;
         if (misaligned) miss++;
         if (load_valid) begin lvs++; lv_data = load_data; end
         if (mem_req) begin
            if (reqs == 0) begin a = mem_addr; be = mem_be; wd = mem_wdata; we = mem_we; end
            if (reqs == flush_at) flush = 1'b1;
            if (reqs == ack_at) begin mem_ack = 1'b1; mem_rdata = rdata; end
            reqs++;
         end
         drop = req_valid && !stall_m;
         @(posedge clk); #1;
         mem_ack = 1'b0; flush = 1'b0;
         if (drop) begin
            req_valid = 1'b0; tail = 2;
         end else if (tail > 0) begin
            tail--;
            if (tail == 0) begin timed_out = 1'b0; break; end
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; flush = 1'b0; mem_ack = 1'b0;
      req_addr = '0; req_wdata = '0; mem_rdata = '0; req_store_type = '0; req_trunc_type = '0;
      #3;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
      checks++; if (mem_be !== 4'h0) begin errors++; $display("[TB] FAIL reset_mem_be: got %h want 0", mem_be); end
      checks++; if (load_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_load_data: got %h want 0", load_data); end
      checks++; if ({load_valid, misaligned, stall_m, mem_we} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b want 0000", {load_valid, misaligned, stall_m, mem_we}); end
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_load_byte();
      int s, r, l, m; logic [31:0] d, a, wd; logic [3:0] be; logic we, to; expect_t e;
      sb.push_back('{addr: 32'h1000, be: 4'hF, wdata: 'x, we: 1'b0, data: 32'hFFFF_FF80});
      run_txn(1'b0, 32'h1003, 32'h0, ST_BYTE, TT_BYTE, 32'h80FF_1234, 0, -1, s, r, l, m, d, a, be, wd, we, to);
      e = sb.pop_front();
      checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL lb_timeout: transaction did not finish"); end
      checks++; if (a !== e.addr) begin errors++; $display("[TB] FAIL lb_addr: got %h want %h", a, e.addr); end
      checks++; if ({be, we} !== {e.be, e.we}) begin errors++; $display("[TB] FAIL lb_be_we: got %h/%b want %h/%b", be, we, e.be, e.we); end
      checks++; if (s !== 2) begin errors++; $display("[TB] FAIL lb_stall: got %0d cycles want 2", s); end
      checks++; if (l !== 1) begin errors++; $display("[TB] FAIL lb_load_valid: got %0d pulses want 1", l); end
      checks++; if (d !== e.data) begin errors++; $display("[TB] FAIL lb_data: got %h want %h", d, e.data); end
   endtask

   task automatic test_store_half();
      int s, r, l, m; logic [31:0] d, a, wd; logic [3:0] be; logic we, to; expect_t e;
      sb.push_back('{addr: 32'h2000, be: 4'b1100, wdata: 32'hABCD_0000, we: 1'b1, data: 'x});
      run_txn(1'b1, 32'h2002, 32'h0000_ABCD, ST_HALF, TT_NONE, 32'h0, 0, -1, s, r, l, m, d, a, be, wd, we, to);
      e = sb.pop_front();
      checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL sh_timeout: transaction did not finish"); end
      checks++; if (a !== e.addr) begin errors++; $display("[TB] FAIL sh_addr: got %h want %h", a, e.addr); end
      checks++; if (be !== e.be) begin errors++; $display("[TB] FAIL sh_be: got %b want %b", be, e.be); end
      checks++; if (wd !== e.wdata) begin errors++; $display("[TB] FAIL sh_wdata: got %h want %h", wd, e.wdata); end
      checks++; if (we !== e.we) begin errors++; $display("[TB] FAIL sh_we: got %b want %b", we, e.we); end
      checks++; if (l !== 0) begin errors++; $display("[TB] FAIL sh_no_load_valid: got %0d pulses want 0", l); end
   endtask

   task automatic test_store_byte_word();
      int s, r, l, m; logic [31:0] d, a, wd; logic [3:0] be; logic we, to;
      logic [31:0] addrs[2] = '{32'h2101, 32'h2104};
      logic [1:0]  sts[2]   = '{ST_BYTE, ST_WORD};
      logic [31:0] wds[2]   = '{32'h0000_005A, 32'h1234_5678};
      logic [3:0]  bes[2]   = '{4'b0010, 4'b1111};
      logic [31:0] wexp[2]  = '{32'h0000_5A00, 32'h1234_5678};
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{addr: {addrs[i][31:2], 2'b00}, be: bes[i], wdata: wexp[i], we: 1'b1, data: 'x});
         run_txn(1'b1, addrs[i], wds[i], sts[i], TT_NONE, 32'h0, 0, -1, s, r, l, m, d, a, be, wd, we, to);
         begin
            expect_t e = sb.pop_front();
            checks++; if ({to, a, be, wd} !== {1'b0, e.addr, e.be, e.wdata}) begin errors++; $display("[TB] FAIL store_%0d: got to=%b addr=%h be=%b wdata=%h want addr=%h be=%b wdata=%h", i, to, a, be, wd, e.addr, e.be, e.wdata); end
         end
      end
   endtask

   task automatic test_misaligned();
      int s, r, l, m; logic [31:0] d, a, wd; logic [3:0] be; logic we, to;
      run_txn(1'b0, 32'h3001, 32'h0, ST_BYTE, TT_WORD, 32'h0, 0, -1, s, r, l, m, d, a, be, wd, we, to);
      checks++; if (m !== 1) begin errors++; $display("[TB] FAIL mis_pulse: got %0d pulses want 1", m); end
      checks++; if (r !== 0) begin errors++; $display("[TB] FAIL mis_no_req: got %0d request cycles want 0", r); end
      checks++; if (s !== 0) begin errors++; $display("[TB] FAIL mis_stall: got %0d cycles want 0", s); end
      run_txn(1'b1, 32'h3004, 32'h0, 2'd3, TT_NONE, 32'h0, 0, -1, s, r, l, m, d, a, be, wd, we, to);
      checks++; if ({m, r} !== {32'd1, 32'd0}) begin errors++; $display("[TB] FAIL mis_sd: got pulses=%0d reqs=%0d want 1/0", m, r); end
   endtask

   task automatic test_half_unsigned_wait();
      int s, r, l, m; logic [31:0] d, a, wd; logic [3:0] be; logic we, to; expect_t e;
      sb.push_back('{addr: 32'h4000, be: 4'hF, wdata: 'x, we: 1'b0, data: 32'h0000_9876});
      run_txn(1'b0, 32'h4002, 32'h0, ST_BYTE, TT_HALF_U, 32'h9876_0000, 2, -1, s, r, l, m, d, a, be, wd, we, to);
      e = sb.pop_front();
      checks++; if (s !== 4) begin errors++; $display("[TB] FAIL lhu_stall: got %0d cycles want 4", s); end
      checks++; if (r !== 3) begin errors++; $display("[TB] FAIL lhu_req_cycles: got %0d want 3", r); end
      checks++; if ({l, d} !== {32'd1, e.data}) begin errors++; $display("[TB] FAIL lhu_data: got %0d pulses data %h want 1 pulse data %h", l, d, e.data); end
   endtask

   task automatic test_flush();
      int s, r, l, m; logic [31:0] d, a, wd; logic [3:0] be; logic we, to;
      run_txn(1'b0, 32'h5000, 32'h0, ST_BYTE, TT_WORD, 32'h1111_2222, 1, 0, s, r, l, m, d, a, be, wd, we, to);
      checks++; if (l !== 0) begin errors++; $display("[TB] FAIL flush_load_valid: got %0d pulses want 0", l); end
      checks++; if ({to, r} !== {1'b0, 32'd2}) begin errors++; $display("[TB] FAIL flush_bus: got to=%b reqs=%0d want 0/2", to, r); end
      checks++; if (load_data !== 32'h0000_9876) begin errors++; $display("[TB] FAIL flush_data_held: got %h want 00009876", load_data); end
      checks++; if ({stall_m, mem_req} !== 2'b00) begin errors++; $display("[TB] FAIL flush_idle: got stall/req %b want 00", {stall_m, mem_req}); end
   endtask

   task automatic test_load_variants();
      int s, r, l, m; logic [31:0] d, a, wd; logic [3:0] be; logic we, to; expect_t e;
      logic [31:0] addrs[4] = '{32'h6001, 32'h6002, 32'h6000, 32'h6003};
      logic [31:0] rds[4]   = '{32'hAABB_CC11, 32'h8001_0000, 32'hDEAD_BEEF, 32'h7F00_0000};
      logic [2:0]  tts[4]   = '{TT_BYTE_U, TT_HALF, TT_NONE, TT_BYTE};
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{addr: {addrs[i][31:2], 2'b00}, be: 4'hF, wdata: 'x, we: 1'b0,
                        data: model_load(rds[i], addrs[i][1:0], tts[i])});
         run_txn(1'b0, addrs[i], 32'h0, ST_BYTE, tts[i], rds[i], i % 2, -1, s, r, l, m, d, a, be, wd, we, to);
         e = sb.pop_front();
         checks++; if ({l, a, d} !== {32'd1, e.addr, e.data}) begin errors++; $display("[TB] FAIL load_var_%0d: got pulses=%0d addr=%h data=%h want 1/%h/%h", i, l, a, d, e.addr, e.data); end
      end
   endtask

   task automatic test_reset_in_flight();
      int s, r, l, m; logic [31:0] d, a, wd; logic [3:0] be; logic we, to; expect_t e;
      @(posedge clk); #1;
      req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h7000; req_trunc_type = TT_WORD;
      @(posedge clk); @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rif_wait: got mem_req %b want 1", mem_req); end
      #1; reset_n = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; req_valid = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rif_req_drop: got %b want 0", mem_req); end
      checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin errors++; $display("[TB] FAIL rif_bus_zero: got addr=%h wdata=%h be=%h want 0", mem_addr, mem_wdata, mem_be); end
      checks++; if ({load_data, load_valid, misaligned, stall_m, mem_we} !== 36'h0) begin errors++; $display("[TB] FAIL rif_out_zero: got data=%h flags=%b want 0", load_data, {load_valid, misaligned, stall_m, mem_we}); end
      @(posedge clk); @(negedge clk);
      checks++; if ({mem_req, load_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rif_ack_ignored: got %b want 00", {mem_req, load_valid}); end
      mem_ack = 1'b0; reset_n = 1'b1;
      sb.push_back('{addr: 32'h7004, be: 4'hF, wdata: 'x, we: 1'b0, data: 32'h1357_2468});
      run_txn(1'b0, 32'h7004, 32'h0, ST_BYTE, TT_WORD, 32'h1357_2468, 0, -1, s, r, l, m, d, a, be, wd, we, to);
      e = sb.pop_front();
      checks++; if ({to, l, a, d} !== {1'b0, 32'd1, e.addr, e.data}) begin errors++; $display("[TB] FAIL rif_after: got to=%b pulses=%0d addr=%h data=%h want 0/1/%h/%h", to, l, a, d, e.addr, e.data); end
   endtask

   task automatic test_back_to_back();
      int s, r, l, m; logic [31:0] d, a, wd; logic [3:0] be; logic we, to; expect_t e;
      sb.push_back('{addr: 32'h8000, be: 4'hF, wdata: 'x, we: 1'b0, data: 32'hFFFF_A5A5});
      sb.push_back('{addr: 32'h8004, be: 4'hF, wdata: 'x, we: 1'b0, data: 32'h0000_00C3});
      run_txn(1'b0, 32'h8000, 32'h0, ST_BYTE, TT_HALF, 32'h0000_A5A5, 0, -1, s, r, l, m, d, a, be, wd, we, to);
      e = sb.pop_front();
      checks++; if ({l, d} !== {32'd1, e.data}) begin errors++; $display("[TB] FAIL b2b_first: got %0d/%h want 1/%h", l, d, e.data); end
      run_txn(1'b0, 32'h8007, 32'h0, ST_BYTE, TT_BYTE_U, 32'hC300_0000, 1, -1, s, r, l, m, d, a, be, wd, we, to);
      e = sb.pop_front();
      checks++; if ({l, a, d, s} !== {32'd1, e.addr, e.data, 32'd3}) begin errors++; $display("[TB] FAIL b2b_second: got pulses=%0d addr=%h data=%h stall=%0d want 1/%h/%h/3", l, a, d, s, e.addr, e.data); end
   endtask

   initial begin
      test_reset();
      test_load_byte();
      test_store_half();
      test_store_byte_word();
      test_misaligned();
      test_half_unsigned_wait();
      test_flush();
      test_load_variants();
      test_reset_in_flight();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
